// File: rtl/stream_downsizer.sv
// Width down-converter: one IN_WIDTH word in, RATIO OUT_WIDTH beats out, LSB slice first.
// Optional even-parity output enabled by defining DOWNSIZER_PARITY_EN.
module stream_downsizer #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned RATIO     = IN_WIDTH / OUT_WIDTH,
  parameter int unsigned CNT_WIDTH = $clog2(RATIO)
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  output logic                 in_rdy_o,
  input  logic                 in_vld_i,
  input  logic [IN_WIDTH-1:0]  in_data_i,
  input  logic                 out_rdy_i,
  output logic                 out_vld_o,
  output logic [OUT_WIDTH-1:0] out_data_o,
  output logic                 out_last_o,
  output logic [CNT_WIDTH-1:0] beat_idx_o
`ifdef DOWNSIZER_PARITY_EN
  ,
  output logic                 out_par_o
`endif
);

  if (RATIO < 2 || (IN_WIDTH % OUT_WIDTH) != 0 || RATIO != IN_WIDTH / OUT_WIDTH) begin : g_bad_cfg
    $error("stream_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH with RATIO >= 2");
  end

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(RATIO - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t               state_q;
  logic [IN_WIDTH-1:0]  shift_q;
  logic [CNT_WIDTH-1:0] next_idx;
  logic                 in_acc;
  logic                 out_acc;
  logic                 advance;
  logic                 drain;

  assign in_rdy_o = (state_q == IDLE) || (out_vld_o && out_rdy_i && out_last_o);
  assign in_acc   = in_vld_i && in_rdy_o;
  assign out_acc  = out_vld_o && out_rdy_i;
  assign next_idx = beat_idx_o + CNT_WIDTH'(1);

  // A load covers both the IDLE start and the zero-bubble reload on the last beat,
  // since in_rdy_o is only high in those two situations.
  assign advance  = out_acc && !out_last_o;
  assign drain    = out_acc && out_last_o && !in_acc;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      out_vld_o  <= 1'b0;
      out_data_o <= '0;
      out_last_o <= 1'b0;
      beat_idx_o <= '0;
`ifdef DOWNSIZER_PARITY_EN
      out_par_o  <= 1'b0;
`endif
    end else if (in_acc) begin
      state_q    <= SEND;
      shift_q    <= in_data_i >> OUT_WIDTH;
      out_vld_o  <= 1'b1;
      out_data_o <= in_data_i[OUT_WIDTH-1:0];
      out_last_o <= 1'b0;
      beat_idx_o <= '0;
`ifdef DOWNSIZER_PARITY_EN
      out_par_o  <= ^in_data_i[OUT_WIDTH-1:0];
`endif
    end else if (advance) begin
      shift_q    <= shift_q >> OUT_WIDTH;
      out_data_o <= shift_q[OUT_WIDTH-1:0];
      out_last_o <= (next_idx == LAST_IDX);
      beat_idx_o <= next_idx;
`ifdef DOWNSIZER_PARITY_EN
      out_par_o  <= ^shift_q[OUT_WIDTH-1:0];
`endif
    end else if (drain) begin
      state_q    <= IDLE;
      out_vld_o  <= 1'b0;
      out_last_o <= 1'b0;
`ifdef DOWNSIZER_PARITY_EN
      out_par_o  <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_stream_downsizer.sv
// Self-checking bench for stream_downsizer (32 -> 8): directed table, corner sequences,
// and randomized traffic checked against a word/beat-count reference model.
module tb_stream_downsizer;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        in_rdy_o;
  logic        in_vld_i = 1'b0;
  logic [31:0] in_data_i = '0;
  logic        out_rdy_i = 1'b0;
  logic        out_vld_o;
  logic [7:0]  out_data_o;
  logic        out_last_o;
  logic [1:0]  beat_idx_o;
`ifdef DOWNSIZER_PARITY_EN
  logic        out_par_o;
`endif

  stream_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .in_rdy_o   (in_rdy_o),
    .in_vld_i   (in_vld_i),
    .in_data_i  (in_data_i),
    .out_rdy_i  (out_rdy_i),
    .out_vld_o  (out_vld_o),
    .out_data_o (out_data_o),
    .out_last_o (out_last_o),
    .beat_idx_o (beat_idx_o)
`ifdef DOWNSIZER_PARITY_EN
    ,
    .out_par_o  (out_par_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference model: the word being emitted and how many of its beats remain.
  logic [31:0] m_word = '0;
  int          m_left = 0;

  typedef struct packed {
    logic [31:0]     word;
    logic [3:0][7:0] beats;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check(input string tag);
    logic [7:0] eb;
    eb = 8'(m_word >> (8 * (4 - m_left)));
    chk({tag, "_vld"}, 32'(out_vld_o), 32'(m_left > 0));
    chk({tag, "_rdy"}, 32'(in_rdy_o), 32'((m_left == 0) || (out_rdy_i && m_left == 1)));
    if (m_left > 0) begin
      chk({tag, "_data"}, 32'(out_data_o), 32'(eb));
      chk({tag, "_idx"}, 32'(beat_idx_o), 32'(4 - m_left));
      chk({tag, "_last"}, 32'(out_last_o), 32'(m_left == 1));
    end
`ifdef DOWNSIZER_PARITY_EN
    chk({tag, "_par"}, 32'(out_par_o), 32'((m_left > 0) ? ^eb : 1'b0));
`endif
  endtask

  task automatic tick(output bit in_acc, output bit out_acc);
    logic [31:0] d;
    out_acc = (m_left > 0) && out_rdy_i;
    in_acc  = in_vld_i && ((m_left == 0) || (out_acc && m_left == 1));
    d = in_data_i;
    @(posedge clk_i);
    #1;
    if (out_acc) m_left--;
    if (in_acc) begin
      m_word = d;
      m_left = 4;
    end
  endtask

  task automatic drive(input logic vld, input logic [31:0] data, input logic ordy, input string tag);
    bit ia, oa;
    in_vld_i  = vld;
    in_data_i = data;
    out_rdy_i = ordy;
    #1;
    model_check(tag);
    tick(ia, oa);
  endtask

  initial begin
    vec_t        tbl [4];
    bit          ia, oa;
    logic [31:0] b2b [2];
    logic [7:0]  bp_exp [3];
    int          wi;
    logic [31:0] src [$];
    logic [31:0] sent [$];
    logic [31:0] word_acc;
    logic [7:0]  od;
    logic [1:0]  oi;
    logic        ol;
    int          nbeats, nlast, got, cyc;

    tbl[0] = '{word: 32'hDDCCBBAA, beats: {8'hDD, 8'hCC, 8'hBB, 8'hAA}};
    tbl[1] = '{word: 32'h44332211, beats: {8'h44, 8'h33, 8'h22, 8'h11}};
    tbl[2] = '{word: 32'hFF00FF00, beats: {8'hFF, 8'h00, 8'hFF, 8'h00}};
    tbl[3] = '{word: 32'h80000001, beats: {8'h80, 8'h00, 8'h00, 8'h01}};

    // Power-on reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_vld", 32'(out_vld_o), 0);
    chk("rst_data", 32'(out_data_o), 0);
    chk("rst_last", 32'(out_last_o), 0);
    chk("rst_idx", 32'(beat_idx_o), 0);
    chk("rst_rdy", 32'(in_rdy_o), 1);
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Table-driven single words with the downstream always ready
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, tbl[i].word, 1'b1, "tbl_load");
      for (int k = 0; k < 4; k++) begin
        in_vld_i  = 1'b0;
        in_data_i = $urandom;
        out_rdy_i = 1'b1;
        #1;
        chk("tbl_beat", 32'(out_data_o), 32'(tbl[i].beats[k]));
        chk("tbl_bidx", 32'(beat_idx_o), 32'(k));
        chk("tbl_blast", 32'(out_last_o), 32'(k == 3));
        model_check("tbl");
        tick(ia, oa);
      end
      #1;
      chk("tbl_idle_vld", 32'(out_vld_o), 0);
    end

    // Back-to-back words: zero bubble, in_rdy_o only on last-beat cycles
    b2b[0] = 32'h03020100;
    b2b[1] = 32'h07060504;
    drive(1'b1, b2b[0], 1'b1, "b2b_load");
    wi = 1;
    for (int c = 0; c < 8; c++) begin
      in_vld_i  = (wi < 2);
      in_data_i = (wi < 2) ? b2b[wi] : 32'hDEADBEEF;
      out_rdy_i = 1'b1;
      #1;
      chk("b2b_vld", 32'(out_vld_o), 1);
      chk("b2b_data", 32'(out_data_o), 32'(c));
      chk("b2b_inrdy", 32'(in_rdy_o), 32'(c == 3 || c == 7));
      model_check("b2b");
      tick(ia, oa);
      if (ia) wi++;
    end
    #1;
    chk("b2b_end_vld", 32'(out_vld_o), 0);

    // Backpressure for 5 cycles on beat 1
    drive(1'b1, 32'h44332211, 1'b1, "bp_load");
    drive(1'b0, 32'h0, 1'b1, "bp_b0");
    for (int c = 0; c < 5; c++) begin
      in_vld_i  = 1'b1;
      in_data_i = $urandom;
      out_rdy_i = 1'b0;
      #1;
      chk("bp_hold_data", 32'(out_data_o), 32'h22);
      chk("bp_hold_idx", 32'(beat_idx_o), 1);
      chk("bp_inrdy", 32'(in_rdy_o), 0);
      model_check("bp");
      tick(ia, oa);
    end
    bp_exp[0] = 8'h22;
    bp_exp[1] = 8'h33;
    bp_exp[2] = 8'h44;
    for (int c = 0; c < 3; c++) begin
      in_vld_i  = 1'b0;
      out_rdy_i = 1'b1;
      #1;
      chk("bp_rel_data", 32'(out_data_o), 32'(bp_exp[c]));
      model_check("bp_rel");
      tick(ia, oa);
    end
    #1;
    chk("bp_end_vld", 32'(out_vld_o), 0);

    // Asynchronous reset mid-word discards the partial word
    drive(1'b1, 32'h12345678, 1'b1, "ar_load");
    drive(1'b0, 32'h0, 1'b1, "ar_b0");
    out_rdy_i = 1'b0;
    #1;
    chk("ar_pre_data", 32'(out_data_o), 32'h56);
    rstn_i = 1'b0;
    #1;
    chk("ar_vld", 32'(out_vld_o), 0);
    chk("ar_last", 32'(out_last_o), 0);
    chk("ar_idx", 32'(beat_idx_o), 0);
    chk("ar_data", 32'(out_data_o), 0);
    m_left = 0;
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    #1;
    chk("ar_inrdy", 32'(in_rdy_o), 1);
    @(posedge clk_i);
    #1;

    // Randomized traffic with in-order reassembly
    for (int i = 0; i < 1000; i++) src.push_back($urandom);
    nbeats = 0;
    nlast  = 0;
    got    = 0;
    cyc    = 0;
    word_acc = '0;
    while (got < 1000 && cyc < 20000) begin
      in_vld_i  = (src.size() > 0) && ($urandom_range(0, 3) != 0);
      in_data_i = in_vld_i ? src[0] : $urandom;
      out_rdy_i = ($urandom_range(0, 2) != 0);
      #1;
      model_check("rnd");
      od = out_data_o;
      oi = beat_idx_o;
      ol = out_last_o;
      tick(ia, oa);
      if (ia) sent.push_back(src.pop_front());
      if (oa) begin
        word_acc[8*oi +: 8] = od;
        nbeats++;
        if (ol) begin
          nlast++;
          got++;
          chk("reasm_pending", 32'(sent.size() > 0), 1);
          if (sent.size() > 0) chk("reasm_word", word_acc, sent.pop_front());
        end
      end
      cyc++;
    end
    chk("rnd_timeout", 32'(cyc < 20000), 1);
    chk("rnd_beats", 32'(nbeats), 4000);
    chk("rnd_lasts", 32'(nlast), 1000);
    chk("rnd_src_empty", 32'(src.size()), 0);

`ifdef DOWNSIZER_PARITY_EN
    // Parity on specific beat values
    drive(1'b1, 32'h00000307, 1'b1, "par_load");
    in_vld_i = 1'b0;
    #1;
    chk("par_07", 32'(out_par_o), 1);
    tick(ia, oa);
    #1;
    chk("par_03", 32'(out_par_o), 0);
    tick(ia, oa);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
